// File: rtl/flash_req_arbiter.sv
// flash_req_arbiter: shares one SPI flash controller between two requesters.
// It grants one requester at a time using round-robin order and latches that
// requester's command. The command is held stable until the controller
// answers or the timeout expires. Each command is followed by one idle GAP
// cycle before the next arbitration.
//
// Handshake: a requester raises mX_req with write/addr/wdata stable and keeps
// them until mX_ack pulses. In the cycle after mX_ack the requester must have
// req low. Otherwise IDLE samples req as a fresh request. Toward the
// controller, flash_en is high for the whole command and the command fields do
// not change while it is high. A single-cycle flash_ready ends the command.
// flash_data_out is sampled only in the flash_ready cycle.
module flash_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int CNT_W          = 23
) (
    input  logic        clk_50MHz,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_write,
    input  logic [23:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_write,
    input  logic [23:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,

    output logic        flash_en,
    output logic        flash_write,
    output logic [23:0] flash_addr,
    output logic [31:0] flash_data_in,
    input  logic [31:0] flash_data_out,
    input  logic        flash_ready,

    output logic        busy,
    output logic        owner,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // The controller works on word addresses, so the byte-lane bits are cleared.
    localparam logic [23:0]      ADDR_MASK = 24'hFF_FFFC;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             grant_valid;
    logic             grant_sel;
    logic             grant;
    logic             timeout_hit;
    logic             done;

    // Round-robin winner: on a tie the port that was not granted last wins.
    always_comb begin
        grant_valid = m0_req | m1_req;
        grant_sel   = 1'b0;
        if (m0_req && m1_req) begin
            grant_sel = ~last;
        end else if (m1_req) begin
            grant_sel = 1'b1;
        end
    end

    assign grant       = (state == ST_IDLE) && grant_valid;
    assign timeout_hit = (state == ST_BUSY) && (cnt == CNT_LAST);
    // The command ends on a flash_ready pulse or at the timeout limit.
    // A flash_ready pulse in IDLE or GAP is ignored.
    assign done        = (state == ST_BUSY) && (flash_ready || timeout_hit);

    // Next-state logic: IDLE -> BUSY on grant, BUSY -> GAP on done, GAP -> IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (grant_valid) state_nxt = ST_BUSY;
            ST_BUSY: if (done)        state_nxt = ST_GAP;
            ST_GAP:                   state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // State register. A reset in any state returns to IDLE on the next edge.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Timeout counter: cleared while IDLE so it starts at 0 in the first
    // BUSY cycle. It counts up only in BUSY, so it cannot wrap before the limit.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == ST_IDLE) begin
            cnt <= '0;
        end else if (state == ST_BUSY) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Command capture on grant. The fields stay frozen until the next grant.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            owner         <= 1'b0;
            last          <= 1'b1;
            flash_write   <= 1'b0;
            flash_addr    <= '0;
            flash_data_in <= '0;
        end else if (grant) begin
            owner <= grant_sel;
            last  <= grant_sel;
            if (grant_sel) begin
                flash_write   <= m1_write;
                flash_addr    <= m1_addr & ADDR_MASK;
                flash_data_in <= m1_wdata;
            end else begin
                flash_write   <= m0_write;
                flash_addr    <= m0_addr & ADDR_MASK;
                flash_data_in <= m0_wdata;
            end
        end
    end

    // Completion: a registered ack pulses for the owner. err pulses with the
    // ack only when the timeout ended the command and flash_ready was low.
    // Read data is captured only on a read that got flash_ready.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            m0_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= '0;
            m1_ack   <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= '0;
        end else begin
            m0_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_ack <= 1'b0;
            m1_err <= 1'b0;
            if (done) begin
                if (owner) begin
                    m1_ack <= 1'b1;
                    m1_err <= ~flash_ready;
                    if (flash_ready && !flash_write) begin
                        m1_rdata <= flash_data_out;
                    end
                end else begin
                    m0_ack <= 1'b1;
                    m0_err <= ~flash_ready;
                    if (flash_ready && !flash_write) begin
                        m0_rdata <= flash_data_out;
                    end
                end
            end
        end
    end

    assign flash_en  = (state == ST_BUSY);
    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_flash_req_arbiter.sv
// Directed testbench for flash_req_arbiter (TIMEOUT_CYCLES = 16).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_flash_req_arbiter;

    logic        clk_50MHz = 1'b0;
    logic        reset;
    logic        m0_req, m0_write, m1_req, m1_write;
    logic [23:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        flash_en, flash_write, flash_ready;
    logic [23:0] flash_addr;
    logic [31:0] flash_data_in, flash_data_out;
    logic        busy, owner;
    logic [1:0]  fsm_state;

    int n_cmp  = 0;
    int n_fail = 0;

    flash_req_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk_50MHz(clk_50MHz), .reset(reset),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .flash_en(flash_en), .flash_write(flash_write), .flash_addr(flash_addr),
        .flash_data_in(flash_data_in), .flash_data_out(flash_data_out),
        .flash_ready(flash_ready), .busy(busy), .owner(owner), .fsm_state(fsm_state)
    );

    // Clock and watchdog
    always #10 clk_50MHz = ~clk_50MHz;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick;
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Scenario tasks
    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({flash_en, busy, owner, flash_write} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: en/busy/owner/wr=%b required 0000", {flash_en, busy, owner, flash_write});
        end
        n_cmp++;
        if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ack: ack/err=%b required 0000", {m0_ack, m0_err, m1_ack, m1_err});
        end
        n_cmp++;
        if ({m0_rdata, m1_rdata, flash_addr, flash_data_in} !== 120'd0) begin
            n_fail++;
            $display("FAIL reset_data: m0_rdata=%h m1_rdata=%h addr=%h din=%h required all 0",
                     m0_rdata, m1_rdata, flash_addr, flash_data_in);
        end
        n_cmp++;
        if (fsm_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d required 0", fsm_state);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: busy=%b required 0", busy);
        end
    endtask

    task automatic test_single_read;
        m0_write = 1'b0;
        m0_addr  = 24'h000107;
        m0_req   = 1'b1;
        tick();
        n_cmp++;
        if ({flash_en, busy, owner, flash_write} !== 4'b1100) begin
            n_fail++;
            $display("FAIL read_grant: en/busy/owner/wr=%b required 1100", {flash_en, busy, owner, flash_write});
        end
        n_cmp++;
        if (flash_addr !== 24'h000104) begin
            n_fail++;
            $display("FAIL read_addr: flash_addr=%h required 000104", flash_addr);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (flash_en !== 1'b1 || m0_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL read_hold: cycle %0d en=%b ack=%b required en=1 ack=0", i, flash_en, m0_ack);
            end
        end
        flash_ready    = 1'b1;
        flash_data_out = 32'hDEADBEEF;
        tick();
        flash_ready = 1'b0;
        m0_req      = 1'b0;
        n_cmp++;
        if ({m0_ack, m0_err, m1_ack, flash_en} !== 4'b1000) begin
            n_fail++;
            $display("FAIL read_done: m0_ack/m0_err/m1_ack/en=%b required 1000", {m0_ack, m0_err, m1_ack, flash_en});
        end
        n_cmp++;
        if (m0_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL read_data: m0_rdata=%h required deadbeef", m0_rdata);
        end
        tick();
        n_cmp++;
        if ({m0_ack, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL read_after: ack/busy=%b required 00 (one-cycle ack, single gap)", {m0_ack, busy});
        end
    endtask

    task automatic test_back_to_back;
        int   grants, acks, low_cnt, en_cnt;
        logic prev_en, m0_hold, m1_hold;
        apply_reset();
        m0_write = 1'b0;
        m1_write = 1'b0;
        m0_addr  = 24'h000200;
        m1_addr  = 24'h000300;
        m0_req   = 1'b1;
        m1_req   = 1'b1;
        grants = 0; acks = 0; low_cnt = 0; en_cnt = 0;
        prev_en = 1'b0; m0_hold = 1'b0; m1_hold = 1'b0;
        for (int cyc = 0; cyc < 200 && acks < 4; cyc++) begin
            tick();
            if (flash_en && !prev_en) begin
                n_cmp++;
                if (owner !== grants[0]) begin
                    n_fail++;
                    $display("FAIL rr_order: grant %0d owner=%b required %b", grants, owner, grants[0]);
                end
                if (grants > 0) begin
                    n_cmp++;
                    if (low_cnt != 2) begin
                        n_fail++;
                        $display("FAIL rr_gap: grant %0d idle cycles=%0d required 2", grants, low_cnt);
                    end
                end
                grants++;
            end
            if (flash_en) low_cnt = 0;
            else          low_cnt++;
            if (m0_ack || m1_ack) begin
                n_cmp++;
                if ({m1_ack, m0_ack} !== (acks[0] ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL rr_ack: ack %0d m1/m0=%b required %b", acks, {m1_ack, m0_ack},
                             acks[0] ? 2'b10 : 2'b01);
                end
                n_cmp++;
                if ((acks[0] ? m1_rdata : m0_rdata) !== 32'hA000_0000 + 32'(acks)) begin
                    n_fail++;
                    $display("FAIL rr_data: ack %0d rdata=%h required %h", acks,
                             acks[0] ? m1_rdata : m0_rdata, 32'hA000_0000 + 32'(acks));
                end
                acks++;
            end
            if (m0_ack) begin
                m0_req = 1'b0; m0_hold = 1'b1;
            end else if (m0_hold) begin
                m0_req = (acks <= 2); m0_hold = 1'b0;
            end
            if (m1_ack) begin
                m1_req = 1'b0; m1_hold = 1'b1;
            end else if (m1_hold) begin
                m1_req = (acks <= 2); m1_hold = 1'b0;
            end
            flash_ready = 1'b0;
            if (flash_en) begin
                en_cnt++;
                if (en_cnt == 3) begin
                    flash_ready    = 1'b1;
                    flash_data_out = 32'hA000_0000 + 32'(grants - 1);
                    en_cnt         = 0;
                end
            end
            prev_en = flash_en;
        end
        n_cmp++;
        if (acks != 4 || grants != 4) begin
            n_fail++;
            $display("FAIL rr_count: grants=%0d acks=%0d required 4/4", grants, acks);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        flash_ready = 1'b0;
        tick();
    endtask

    task automatic test_write;
        m1_write = 1'b1;
        m1_addr  = 24'h00ABCD;
        m1_wdata = 32'h12345678;
        m1_req   = 1'b1;
        tick();
        n_cmp++;
        if ({flash_en, owner, flash_write} !== 3'b111 || flash_addr !== 24'h00ABCC) begin
            n_fail++;
            $display("FAIL write_grant: en/owner/wr=%b addr=%h required 111 00abcc", {flash_en, owner, flash_write}, flash_addr);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (flash_data_in !== 32'h12345678 || flash_write !== 1'b1 || flash_en !== 1'b1) begin
                n_fail++;
                $display("FAIL write_stable: cycle %0d din=%h wr=%b en=%b required 12345678 1 1",
                         i, flash_data_in, flash_write, flash_en);
            end
            tick();
        end
        flash_ready    = 1'b1;
        flash_data_out = 32'hBADBAD00;
        tick();
        flash_ready = 1'b0;
        m1_req      = 1'b0;
        n_cmp++;
        if ({m1_ack, m1_err, m0_ack} !== 3'b100) begin
            n_fail++;
            $display("FAIL write_ack: m1_ack/m1_err/m0_ack=%b required 100", {m1_ack, m1_err, m0_ack});
        end
        n_cmp++;
        if (m1_rdata !== 32'hA000_0003) begin
            n_fail++;
            $display("FAIL write_rdata: m1_rdata=%h required a0000003 (unchanged)", m1_rdata);
        end
        tick();
    endtask

    task automatic test_timeout;
        int en_cycles;
        m0_write       = 1'b0;
        m0_addr        = 24'h000010;
        m0_req         = 1'b1;
        flash_data_out = 32'h55555555;
        tick();
        en_cycles = 0;
        for (int i = 0; i < 40 && flash_en; i++) begin
            en_cycles++;
            tick();
        end
        m0_req = 1'b0;
        n_cmp++;
        if (en_cycles != 16) begin
            n_fail++;
            $display("FAIL timeout_len: flash_en high %0d cycles required 16", en_cycles);
        end
        n_cmp++;
        if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b1100) begin
            n_fail++;
            $display("FAIL timeout_ack: m0_ack/m0_err/m1_ack/m1_err=%b required 1100", {m0_ack, m0_err, m1_ack, m1_err});
        end
        n_cmp++;
        if (m0_rdata !== 32'hA000_0002) begin
            n_fail++;
            $display("FAIL timeout_rdata: m0_rdata=%h required a0000002 (unchanged)", m0_rdata);
        end
        tick();
        n_cmp++;
        if ({m0_ack, m0_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_pulse: ack/err=%b required 00", {m0_ack, m0_err});
        end
        tick();
    endtask

    task automatic test_ready_at_limit;
        m1_write = 1'b0;
        m1_addr  = 24'h000020;
        m1_req   = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) tick();
        n_cmp++;
        if (flash_en !== 1'b1 || m1_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL limit_busy: en=%b ack=%b in 16th cycle required 1 0", flash_en, m1_ack);
        end
        flash_ready    = 1'b1;
        flash_data_out = 32'hCAFEF00D;
        tick();
        flash_ready = 1'b0;
        m1_req      = 1'b0;
        n_cmp++;
        if ({m1_ack, m1_err, flash_en} !== 3'b100) begin
            n_fail++;
            $display("FAIL limit_ack: ack/err/en=%b required 100", {m1_ack, m1_err, flash_en});
        end
        n_cmp++;
        if (m1_rdata !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL limit_data: m1_rdata=%h required cafef00d", m1_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_busy;
        m0_write = 1'b0;
        m0_addr  = 24'h000040;
        m0_req   = 1'b1;
        tick();
        tick();
        tick();
        reset  = 1'b1;
        m0_req = 1'b0;
        tick();
        n_cmp++;
        if ({flash_en, busy, m0_ack, m0_err} !== 4'b0000 || fsm_state !== 2'd0) begin
            n_fail++;
            $display("FAIL midreset: en/busy/ack/err=%b state=%0d required 0000 0",
                     {flash_en, busy, m0_ack, m0_err}, fsm_state);
        end
        n_cmp++;
        if (m1_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_rdata: m1_rdata=%h required 0", m1_rdata);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin
                n_fail++;
                $display("FAIL midreset_noack: cycle %0d ack/err=%b required 0000", i, {m0_ack, m0_err, m1_ack, m1_err});
            end
        end
        m0_addr  = 24'h000050;
        m1_addr  = 24'h000060;
        m1_write = 1'b0;
        m0_req   = 1'b1;
        m1_req   = 1'b1;
        tick();
        n_cmp++;
        if (flash_en !== 1'b1 || owner !== 1'b0 || flash_addr !== 24'h000050) begin
            n_fail++;
            $display("FAIL midreset_tie: en=%b owner=%b addr=%h required 1 0 000050", flash_en, owner, flash_addr);
        end
        flash_ready    = 1'b1;
        flash_data_out = 32'h0BADF00D;
        tick();
        flash_ready = 1'b0;
        m0_req      = 1'b0;
        n_cmp++;
        if ({m0_ack, m1_ack} !== 2'b10 || m0_rdata !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL midreset_done: m0/m1 ack=%b rdata=%h required 10 0badf00d", {m0_ack, m1_ack}, m0_rdata);
        end
        tick();
        tick();
        n_cmp++;
        if (flash_en !== 1'b1 || owner !== 1'b1) begin
            n_fail++;
            $display("FAIL waiting_req: en=%b owner=%b required 1 1 (waiting m1 served)", flash_en, owner);
        end
        flash_ready    = 1'b1;
        flash_data_out = 32'h00C0FFEE;
        tick();
        flash_ready = 1'b0;
        m1_req      = 1'b0;
        n_cmp++;
        if (m1_ack !== 1'b1 || m1_rdata !== 32'h00C0FFEE) begin
            n_fail++;
            $display("FAIL waiting_done: m1_ack=%b rdata=%h required 1 00c0ffee", m1_ack, m1_rdata);
        end
        tick();
    endtask

    task automatic test_stray_ready;
        tick();
        flash_ready    = 1'b1;
        flash_data_out = 32'h11111111;
        tick();
        flash_ready = 1'b0;
        tick();
        n_cmp++;
        if ({m0_ack, m1_ack, busy} !== 3'b000 || m0_rdata !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL stray_ready: ack m0/m1/busy=%b m0_rdata=%h required 000 0badf00d",
                     {m0_ack, m1_ack, busy}, m0_rdata);
        end
    endtask

    // Test sequence and final report
    initial begin
        reset = 1'b1;
        m0_req = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_wdata = '0;
        flash_ready = 1'b0; flash_data_out = '0;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_write();
        test_timeout();
        test_ready_at_limit();
        test_reset_mid_busy();
        test_stray_ready();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
